d_mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a single data-memory port. Sits between the core load/store stage (requester 0) and the debug/program-loader requester (requester 1) on one side and one port of `d_mem` on the other. Performs round-robin arbitration, rejects misaligned or out-of-range accesses before they reach memory, and returns responses one cycle after acceptance using the memory's registered read.

---
 rtl/d_mem_pkg.sv | 43 ++++
 rtl/d_mem_arbiter_if.sv | 51 +++++
 rtl/d_mem_arbiter_rr_arbiter2.sv | 39 +++
 rtl/d_mem_arbiter.sv | 95 +++++++++
 tb/tb_d_mem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/d_mem_pkg.sv
// d_mem_pkg: shared definitions for the data-memory arbiter.
//   - Access size encodings carried on req/mem size fields.
//   - Requester IDs (also used as grant-vector bit positions).
//   - Response pipeline record registered between grant and response.
//   - access_err(): rejection check applied to the granted request.
package d_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  // One-deep record of what was granted, used to route the response
  // that appears in the following cycle.
  typedef struct packed {
    logic valid;
    logic owner;
    logic err;
    logic is_load;
  } resp_pipe_t;

  // Illegal size, misalignment for the size, or address past the end of
  // memory all reject the access.
  function automatic logic access_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] mem_bytes);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr[0];
      SIZE_WORD: bad = |addr[1:0];
      default:   bad = 1'b1;
    endcase
    if (addr >= mem_bytes) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/d_mem_arbiter_if.sv
// Bus interfaces for the data-memory arbiter.
//   d_mem_req_if  : one requester's request/response channel.
//                   master = requester, slave = arbiter.
//                   valid/write/addr/wdata/size/is_unsigned -> arbiter,
//                   ready/resp_valid/resp_rdata/resp_err -> requester.
//   d_mem_port_if : single d_mem port.
//                   master = arbiter, slave = memory.
//                   en_write/en_read/addr/din/size/is_unsigned -> memory,
//                   dout -> arbiter (valid the cycle after en_read).
interface d_mem_req_if;
  logic        valid;
  logic        ready;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        is_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output valid, write, addr, wdata, size, is_unsigned,
    input  ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  valid, write, addr, wdata, size, is_unsigned,
    output ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface d_mem_port_if;
  logic        en_write;
  logic        en_read;
  logic [31:0] addr;
  logic [31:0] din;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] dout;

  modport master (
    output en_write, en_read, addr, din, size, is_unsigned,
    input  dout
  );

  modport slave (
    input  en_write, en_read, addr, din, size, is_unsigned,
    output dout
  );
endinterface

// File: rtl/d_mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant.
//   clk, rst : clock, synchronous active-high reset.
//   req[1:0] : request lines (bit = requester ID).
//   grant    : one-hot (or zero) grant, combinational from req.
// On a tie the requester that did not win last time is granted. The
// pointer resets to REQ_DBG so the core wins the first tie.
module rr_arbiter2
  import d_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant_reg;

  always_comb begin
    grant = 2'b00;
    // No grants while reset is held, even if requests are present.
    if (!rst) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant_reg == REQ_DBG) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= REQ_DBG;
    end else if (|grant) begin
      last_grant_reg <= grant[REQ_DBG];
    end
  end

endmodule

// File: rtl/d_mem_arbiter.sv
// d_mem_arbiter: arbitrates the core (r0) and debug/loader (r1)
// requesters onto one d_mem port.
//   clk, rst : clock, synchronous active-high reset.
//   r0, r1   : requester channels (d_mem_req_if.slave).
//   mem      : memory port (d_mem_port_if.master).
// A granted request drives the memory command in the same cycle; its
// response (load data from the memory's registered read, or error)
// is returned to the owner in the next cycle. Rejected accesses take
// the grant slot but never enable the memory.
module d_mem_arbiter
  import d_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  d_mem_req_if.slave    r0,
  d_mem_req_if.slave    r1,
  d_mem_port_if.master  mem
);

  logic [1:0]  grant;
  logic        any_grant;
  logic        sel;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        req_err;
  resp_pipe_t  resp_next;
  resp_pipe_t  resp_reg;
  logic        resp_live;
  logic        resp_data_ok;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   ({r1.valid, r0.valid}),
    .grant (grant)
  );

  assign r0.ready = grant[REQ_CORE];
  assign r1.ready = grant[REQ_DBG];

  // Payload of whichever requester holds the grant.
  always_comb begin
    any_grant    = |grant;
    sel          = grant[REQ_DBG];
    req_write    = sel ? r1.write       : r0.write;
    req_addr     = sel ? r1.addr        : r0.addr;
    req_wdata    = sel ? r1.wdata       : r0.wdata;
    req_size     = sel ? r1.size        : r0.size;
    req_unsigned = sel ? r1.is_unsigned : r0.is_unsigned;
    req_err      = access_err(req_size, req_addr, 32'(MEM_BYTES));
  end

  // Memory command is zero whenever nothing is granted.
  assign mem.en_write    = any_grant &&  req_write && !req_err;
  assign mem.en_read     = any_grant && !req_write && !req_err;
  assign mem.addr        = any_grant ? req_addr     : 32'h0;
  assign mem.din         = any_grant ? req_wdata    : 32'h0;
  assign mem.size        = any_grant ? req_size     : 2'b00;
  assign mem.is_unsigned = any_grant ? req_unsigned : 1'b0;

  always_comb begin
    resp_next = '0;
    if (any_grant) begin
      resp_next.valid   = 1'b1;
      resp_next.owner   = sel;
      resp_next.err     = req_err;
      resp_next.is_load = !req_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_reg <= '0;
    end else begin
      resp_reg <= resp_next;
    end
  end

  // A response registered just before reset asserts is dropped.
  assign resp_live    = resp_reg.valid && !rst;
  assign resp_data_ok = resp_live && resp_reg.is_load && !resp_reg.err;

  assign r0.resp_valid = resp_live && (resp_reg.owner == REQ_CORE);
  assign r1.resp_valid = resp_live && (resp_reg.owner == REQ_DBG);
  assign r0.resp_err   = r0.resp_valid && resp_reg.err;
  assign r1.resp_err   = r1.resp_valid && resp_reg.err;
  assign r0.resp_rdata = (resp_data_ok && resp_reg.owner == REQ_CORE) ? mem.dout : 32'h0;
  assign r1.resp_rdata = (resp_data_ok && resp_reg.owner == REQ_DBG)  ? mem.dout : 32'h0;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// tb_d_mem_arbiter: directed and randomized checks of d_mem_arbiter,
// with a behavioural d_mem (registered read, byte/half/word access,
// sign/zero extension) attached to the memory port.
module tb_d_mem_arbiter;
  import d_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  d_mem_req_if  r0_bus ();
  d_mem_req_if  r1_bus ();
  d_mem_port_if mem_bus ();

  d_mem_arbiter #(.MEM_BYTES(4096)) dut (
    .clk (clk),
    .rst (rst),
    .r0  (r0_bus),
    .r1  (r1_bus),
    .mem (mem_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] ext_load(input logic [1:0] s, input logic u,
                                           input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    case (s)
      2'b00:   return u ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   return u ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // Behavioural d_mem.
  logic [7:0] store [0:4095];
  logic [11:0] fa;
  assign fa = mem_bus.addr[11:0];
  always @(posedge clk) begin
    if (mem_bus.en_write) begin
      store[fa] <= mem_bus.din[7:0];
      if (mem_bus.size != SIZE_BYTE) store[fa + 12'd1] <= mem_bus.din[15:8];
      if (mem_bus.size == SIZE_WORD) begin
        store[fa + 12'd2] <= mem_bus.din[23:16];
        store[fa + 12'd3] <= mem_bus.din[31:24];
      end
    end
    if (mem_bus.en_read) begin
      mem_bus.dout <= ext_load(mem_bus.size, mem_bus.is_unsigned, store[fa],
                               store[fa + 12'd1], store[fa + 12'd2], store[fa + 12'd3]);
    end
  end

  // Bench-side shadow of memory contents for the randomized phase.
  logic [7:0] ref_mem [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s, input logic u);
    if (n == 0) begin
      r0_bus.valid = v; r0_bus.write = w; r0_bus.addr = a;
      r0_bus.wdata = d; r0_bus.size = s; r0_bus.is_unsigned = u;
    end else begin
      r1_bus.valid = v; r1_bus.write = w; r1_bus.addr = a;
      r1_bus.wdata = d; r1_bus.size = s; r1_bus.is_unsigned = u;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Independent statement of the rejection rule.
  function automatic logic exp_err(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'b11) return 1'b1;
    if ((a % (32'd1 << s)) != 0) return 1'b1;
    return a > 32'd4095;
  endfunction

  // Randomized-phase state.
  logic        pend [2];
  logic        p_write [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  logic [1:0]  p_size [2];
  logic        p_uns [2];
  logic        model_last;
  logic        ev, eo, ee;
  logic [31:0] ed;
  int          g;
  int          accepted;
  int          answered;
  logic [11:0] a;
  int          r;
  logic        e;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      store[i]   = 8'h00;
      ref_mem[i] = 8'h00;
    end
    {store[16'h13], store[16'h12], store[16'h11], store[16'h10]} = 32'hDEADBEEF;
    {store[16'h17], store[16'h16], store[16'h15], store[16'h14]} = 32'h12345678;
    {store[16'hFFF], store[16'hFFE], store[16'hFFD], store[16'hFFC]} = 32'hA5A55A5A;

    // Reset with r0 requesting: no grant, everything quiet.
    rst = 1'b1;
    idle();
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0);
    tick(); mid();
    chk("rst_r0_ready", 32'(r0_bus.ready), 32'h0);
    chk("rst_r0_resp_valid", 32'(r0_bus.resp_valid), 32'h0);
    chk("rst_r0_rdata", r0_bus.resp_rdata, 32'h0);
    chk("rst_r0_err", 32'(r0_bus.resp_err), 32'h0);
    chk("rst_r1_resp_valid", 32'(r1_bus.resp_valid), 32'h0);
    chk("rst_en_read", 32'(mem_bus.en_read), 32'h0);
    chk("rst_en_write", 32'(mem_bus.en_write), 32'h0);
    chk("rst_mem_addr", mem_bus.addr, 32'h0);
    tick(); mid();
    chk("rst2_r0_ready", 32'(r0_bus.ready), 32'h0);

    // Contention: grants r0, r1, r0, r1.
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0);
    drive(1, 1'b1, 1'b0, 32'h14, 32'h0, SIZE_WORD, 1'b0);
    mid();
    chk("cont1_r0_ready", 32'(r0_bus.ready), 32'h1);
    chk("cont1_r1_ready", 32'(r1_bus.ready), 32'h0);
    chk("cont1_mem_addr", mem_bus.addr, 32'h10);
    chk("cont1_en_read", 32'(mem_bus.en_read), 32'h1);
    tick(); mid();
    chk("cont2_r1_ready", 32'(r1_bus.ready), 32'h1);
    chk("cont2_r0_ready", 32'(r0_bus.ready), 32'h0);
    chk("cont2_mem_addr", mem_bus.addr, 32'h14);
    chk("cont2_r0_resp_valid", 32'(r0_bus.resp_valid), 32'h1);
    chk("cont2_r0_rdata", r0_bus.resp_rdata, 32'hDEADBEEF);
    chk("cont2_r1_resp_valid", 32'(r1_bus.resp_valid), 32'h0);
    tick(); mid();
    chk("cont3_r0_ready", 32'(r0_bus.ready), 32'h1);
    chk("cont3_r1_resp_valid", 32'(r1_bus.resp_valid), 32'h1);
    chk("cont3_r1_rdata", r1_bus.resp_rdata, 32'h12345678);
    chk("cont3_r0_resp_valid", 32'(r0_bus.resp_valid), 32'h0);
    tick(); mid();
    chk("cont4_r1_ready", 32'(r1_bus.ready), 32'h1);
    chk("cont4_r0_rdata", r0_bus.resp_rdata, 32'hDEADBEEF);
    tick();
    idle();
    mid();
    chk("cont5_r1_resp_valid", 32'(r1_bus.resp_valid), 32'h1);
    chk("cont5_r1_rdata", r1_bus.resp_rdata, 32'h12345678);
    chk("idle_en_read", 32'(mem_bus.en_read), 32'h0);
    chk("idle_en_write", 32'(mem_bus.en_write), 32'h0);
    chk("idle_mem_addr", mem_bus.addr, 32'h0);
    chk("idle_r0_ready", 32'(r0_bus.ready), 32'h0);

    // Single requester word load.
    tick();
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0);
    mid();
    chk("single_r0_ready", 32'(r0_bus.ready), 32'h1);
    chk("single_en_read", 32'(mem_bus.en_read), 32'h1);
    tick();
    idle();
    mid();
    chk("single_resp_valid", 32'(r0_bus.resp_valid), 32'h1);
    chk("single_rdata", r0_bus.resp_rdata, 32'hDEADBEEF);
    chk("single_err", 32'(r0_bus.resp_err), 32'h0);
    chk("single_r1_resp_valid", 32'(r1_bus.resp_valid), 32'h0);

    // Misaligned / out-of-range rejects from r1.
    tick();
    drive(1, 1'b1, 1'b0, 32'h21, 32'h0, SIZE_HALF, 1'b0);
    mid();
    chk("mis_r1_ready", 32'(r1_bus.ready), 32'h1);
    chk("mis_en_read", 32'(mem_bus.en_read), 32'h0);
    chk("mis_en_write", 32'(mem_bus.en_write), 32'h0);
    tick();
    drive(1, 1'b1, 1'b1, 32'h1002, 32'hCAFEF00D, SIZE_WORD, 1'b0);
    mid();
    chk("mis_resp_valid", 32'(r1_bus.resp_valid), 32'h1);
    chk("mis_resp_err", 32'(r1_bus.resp_err), 32'h1);
    chk("mis_rdata", r1_bus.resp_rdata, 32'h0);
    chk("oor1002_en_write", 32'(mem_bus.en_write), 32'h0);
    tick();
    drive(1, 1'b1, 1'b1, 32'h1000, 32'hCAFEF00D, SIZE_WORD, 1'b0);
    mid();
    chk("oor1002_err", 32'(r1_bus.resp_err), 32'h1);
    chk("oor1000_en_write", 32'(mem_bus.en_write), 32'h0);
    tick();
    drive(1, 1'b1, 1'b0, 32'hFFC, 32'h0, SIZE_WORD, 1'b0);
    mid();
    chk("oor1000_err", 32'(r1_bus.resp_err), 32'h1);
    chk("top_en_read", 32'(mem_bus.en_read), 32'h1);
    tick();
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    mid();
    chk("top_err", 32'(r1_bus.resp_err), 32'h0);
    chk("top_rdata", r1_bus.resp_rdata, 32'hA5A55A5A);
    chk("illegal_en_read", 32'(mem_bus.en_read), 32'h0);

    // Store-then-load, sign/zero extension.
    tick();
    drive(0, 1'b1, 1'b1, 32'h43, 32'h12345680, SIZE_BYTE, 1'b0);
    mid();
    chk("illegal_err", 32'(r0_bus.resp_err), 32'h1);
    chk("illegal_rdata", r0_bus.resp_rdata, 32'h0);
    chk("stb_en_write", 32'(mem_bus.en_write), 32'h1);
    chk("stb_din", mem_bus.din, 32'h12345680);
    tick();
    drive(0, 1'b1, 1'b0, 32'h43, 32'h0, SIZE_BYTE, 1'b0);
    mid();
    chk("stb_resp_valid", 32'(r0_bus.resp_valid), 32'h1);
    chk("stb_resp_err", 32'(r0_bus.resp_err), 32'h0);
    chk("stb_rdata", r0_bus.resp_rdata, 32'h0);
    tick();
    drive(0, 1'b1, 1'b0, 32'h43, 32'h0, SIZE_BYTE, 1'b1);
    mid();
    chk("ldb_signed", r0_bus.resp_rdata, 32'hFFFFFF80);
    chk("ldbu_mem_unsigned", 32'(mem_bus.is_unsigned), 32'h1);
    tick();
    drive(0, 1'b1, 1'b0, 32'h42, 32'h0, SIZE_HALF, 1'b0);
    mid();
    chk("ldb_unsigned", r0_bus.resp_rdata, 32'h00000080);
    tick();
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, SIZE_WORD, 1'b0);
    mid();
    chk("ldh_signed", r0_bus.resp_rdata, 32'hFFFF8000);
    tick();
    idle();
    mid();
    chk("word0_unchanged", r0_bus.resp_rdata, 32'h0);

    // Reset mid-stream: last grant was r0, so only reset makes r0 win the tie.
    tick();
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0);
    mid();
    chk("mrst_grant", 32'(r0_bus.ready), 32'h1);
    tick();
    rst = 1'b1;
    drive(1, 1'b1, 1'b0, 32'h14, 32'h0, SIZE_WORD, 1'b0);
    mid();
    chk("mrst_resp_dropped", 32'(r0_bus.resp_valid), 32'h0);
    chk("mrst_r0_ready", 32'(r0_bus.ready), 32'h0);
    chk("mrst_r1_ready", 32'(r1_bus.ready), 32'h0);
    chk("mrst_en_read", 32'(mem_bus.en_read), 32'h0);
    tick(); mid();
    chk("mrst2_resp_valid", 32'(r0_bus.resp_valid), 32'h0);
    tick();
    rst = 1'b0;
    mid();
    chk("mrst_post_resp_r0", 32'(r0_bus.resp_valid), 32'h0);
    chk("mrst_post_resp_r1", 32'(r1_bus.resp_valid), 32'h0);
    chk("mrst_tie_r0", 32'(r0_bus.ready), 32'h1);
    chk("mrst_tie_r1", 32'(r1_bus.ready), 32'h0);
    tick();
    idle();
    mid();
    chk("mrst_after_rdata", r0_bus.resp_rdata, 32'hDEADBEEF);

    // Randomized idle gaps against a scoreboard.
    model_last = REQ_CORE;
    ev = 1'b0; eo = 1'b0; ee = 1'b0; ed = 32'h0;
    accepted = 0;
    answered = 0;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; p_write[n] = 1'b0; p_addr[n] = 32'h0;
      p_wdata[n] = 32'h0; p_size[n] = 2'b00; p_uns[n] = 1'b0;
    end
    for (int c = 0; c < 1000; c++) begin
      tick();
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 1) == 1) begin
          pend[n]    = 1'b1;
          p_write[n] = 1'($urandom_range(0, 1));
          p_wdata[n] = $urandom;
          p_uns[n]   = 1'($urandom_range(0, 1));
          r          = int'($urandom_range(0, 9));
          p_size[n]  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
          p_addr[n]  = ($urandom_range(0, 15) == 0) ? 32'h1000 + $urandom_range(0, 7)
                                                    : 32'h100 + $urandom_range(0, 63);
        end
        drive(n, pend[n], p_write[n], p_addr[n], p_wdata[n], p_size[n], p_uns[n]);
      end
      mid();
      if (pend[0] && pend[1]) g = (model_last == REQ_DBG) ? 0 : 1;
      else if (pend[0]) g = 0;
      else if (pend[1]) g = 1;
      else g = -1;
      chk("rnd_r0_ready", 32'(r0_bus.ready), 32'(g == 0));
      chk("rnd_r1_ready", 32'(r1_bus.ready), 32'(g == 1));
      chk("rnd_r0_resp_valid", 32'(r0_bus.resp_valid), 32'(ev && eo == 1'b0));
      chk("rnd_r1_resp_valid", 32'(r1_bus.resp_valid), 32'(ev && eo == 1'b1));
      if (r0_bus.resp_valid) answered++;
      if (r1_bus.resp_valid) answered++;
      if (ev) begin
        chk("rnd_resp_err", 32'(eo ? r1_bus.resp_err : r0_bus.resp_err), 32'(ee));
        chk("rnd_resp_rdata", eo ? r1_bus.resp_rdata : r0_bus.resp_rdata, ed);
      end
      if (g < 0) begin
        chk("rnd_idle_en_read", 32'(mem_bus.en_read), 32'h0);
        chk("rnd_idle_en_write", 32'(mem_bus.en_write), 32'h0);
        ev = 1'b0;
        ed = 32'h0;
      end else begin
        accepted++;
        e = exp_err(p_size[g], p_addr[g]);
        chk("rnd_en_read", 32'(mem_bus.en_read), 32'(!p_write[g] && !e));
        chk("rnd_en_write", 32'(mem_bus.en_write), 32'(p_write[g] && !e));
        chk("rnd_mem_addr", mem_bus.addr, p_addr[g]);
        a  = p_addr[g][11:0];
        ed = 32'h0;
        if (!e && p_write[g]) begin
          ref_mem[a] = p_wdata[g][7:0];
          if (p_size[g] != SIZE_BYTE) ref_mem[a + 12'd1] = p_wdata[g][15:8];
          if (p_size[g] == SIZE_WORD) begin
            ref_mem[a + 12'd2] = p_wdata[g][23:16];
            ref_mem[a + 12'd3] = p_wdata[g][31:24];
          end
        end else if (!e) begin
          ed = ext_load(p_size[g], p_uns[g], ref_mem[a], ref_mem[a + 12'd1],
                        ref_mem[a + 12'd2], ref_mem[a + 12'd3]);
        end
        ev = 1'b1;
        eo = 1'(g);
        ee = e;
        model_last = 1'(g);
        pend[g] = 1'b0;
      end
    end
    tick();
    idle();
    mid();
    chk("rnd_last_r0_resp_valid", 32'(r0_bus.resp_valid), 32'(ev && eo == 1'b0));
    chk("rnd_last_r1_resp_valid", 32'(r1_bus.resp_valid), 32'(ev && eo == 1'b1));
    if (r0_bus.resp_valid) answered++;
    if (r1_bus.resp_valid) answered++;
    if (ev) chk("rnd_last_rdata", eo ? r1_bus.resp_rdata : r0_bus.resp_rdata, ed);
    chk("rnd_answered_once", 32'(answered), 32'(accepted));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
